// File: rtl/chacha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chacha_pkg
// Description : Shared types, constants and helpers for the ChaCha block
//               engine: word type, FSM state encoding, sigma constants,
//               quarter-round word-index lookup and 32-bit rotate.
// Revision    : 1.0 - initial release
// ============================================================================
package chacha_pkg;

  typedef logic [31:0] word_t;

  // "expand 32-byte k" constants occupying state words 0..3
  localparam word_t SIGMA0 = 32'h6170_7865;
  localparam word_t SIGMA1 = 32'h3320_646e;
  localparam word_t SIGMA2 = 32'h7962_2d32;
  localparam word_t SIGMA3 = 32'h6b20_6574;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_CALC = 3'd1,
    ST_SUM  = 3'd2,
    ST_OUT  = 3'd3,
    ST_IDLE = 3'd4
  } state_t;

  // State-word index touched by quarter-round operand 'lane' (a=0..d=3) in
  // step 0..7 of a double round. Steps 0..3 walk the columns; steps 4..7
  // walk the diagonals, where row 'lane' is shifted left by 'lane' columns.
  function automatic logic [3:0] qr_idx(input logic [2:0] step,
                                        input logic [1:0] lane);
    logic [1:0] col;
    col = step[1:0] + (step[2] ? lane : 2'd0);
    return {lane, col};
  endfunction

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/chacha_qr.sv
`default_nettype none
// ============================================================================
// Module      : chacha_qr
// Description : Purely combinational ChaCha quarter-round (ARX, rotates
//               16/12/8/7, all additions modulo 2^32).
// Revision    : 1.0 - initial release
// ============================================================================
module chacha_qr
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t na,
  output word_t nb,
  output word_t nc,
  output word_t nd
);

  word_t w_a1, w_b1, w_c1, w_d1;
  word_t w_a2, w_b2, w_c2, w_d2;

  // First half: a+=b, d^=a, d<<<16, c+=d, b^=c, b<<<12
  always_comb begin
    w_a1 = a + b;
    w_d1 = rotl(d ^ w_a1, 16);
    w_c1 = c + w_d1;
    w_b1 = rotl(b ^ w_c1, 12);
  end

  // Second half: a+=b, d^=a, d<<<8, c+=d, b^=c, b<<<7
  always_comb begin
    w_a2 = w_a1 + w_b1;
    w_d2 = rotl(w_d1 ^ w_a2, 8);
    w_c2 = w_c1 + w_d2;
    w_b2 = rotl(w_b1 ^ w_c2, 7);
  end

  assign na = w_a2;
  assign nb = w_b2;
  assign nc = w_c2;
  assign nd = w_d2;

endmodule
`default_nettype wire

// File: rtl/chacha_block_seq.sv
`default_nettype none
// ============================================================================
// Module      : chacha_block_seq
// Description : Sequential ChaCha block engine. Loads the 16-word state over
//               a BUS_W-bit valid/ready stream, runs ROUNDS rounds at one
//               quarter-round per cycle, adds the original state word by
//               word and streams the 64-byte keystream block out. A 'next'
//               pulse in IDLE bumps the block counter and recomputes.
//               Build option CHACHA_CTR64_EN: 64-bit block counter across
//               words 13:12 (word 12 carries into word 13); otherwise the
//               counter is word 12 only and word 13 is never touched.
//               Reset 'rst_n' is asynchronous and active-high.
// Revision    : 1.0 - initial release
// ============================================================================
module chacha_block_seq
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20,
  parameter int BUS_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  input  logic             next,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             busy,
  output logic             key_loaded
);

  localparam int BEATS  = 512 / BUS_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int HALF   = ROUNDS / 2;
  localparam int RND_W  = (HALF > 1) ? $clog2(HALF) : 1;

  state_t             r_state;
  state_t             w_state_nx;
  logic [511:0]       r_init;
  logic [511:0]       r_work;
  logic [BEAT_W-1:0]  r_beat;
  logic [RND_W-1:0]   r_round;
  logic [2:0]         r_step;
  logic               r_key_loaded;

  logic               w_load_fire;
  logic               w_last_beat;
  logic               w_calc_done;
  logic               w_sum_done;
  logic [8:0]         w_beat_lsb;
  logic [8:0]         w_sum_lsb;
  word_t              w_sum_word;
  logic [511:0]       w_init_next;
  word_t              w_ctr_lo;

  logic [3:0]         w_idx_a, w_idx_b, w_idx_c, w_idx_d;
  word_t              w_qa_in, w_qb_in, w_qc_in, w_qd_in;
  word_t              w_qa, w_qb, w_qc, w_qd;

  // Flat 512-bit state: word i at [32i+:32], little-endian bytes, so beat b
  // of the stream is simply bits [b*BUS_W +: BUS_W].
  assign w_beat_lsb  = 9'(r_beat) * 9'(BUS_W);
  assign w_sum_lsb   = {r_beat[3:0], 5'd0};
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_sum_done  = (r_beat[3:0] == 4'd15);
  assign w_calc_done = (r_step == 3'd7) && (r_round == RND_W'(HALF - 1));
  assign w_load_fire = in_valid & in_ready;
  assign w_sum_word  = r_work[w_sum_lsb +: 32] + r_init[w_sum_lsb +: 32];
  assign out_data    = r_work[w_beat_lsb +: BUS_W];
  assign key_loaded  = r_key_loaded;

  // Quarter-round operand selection for the current step
  always_comb begin
    w_idx_a = qr_idx(r_step, 2'd0);
    w_idx_b = qr_idx(r_step, 2'd1);
    w_idx_c = qr_idx(r_step, 2'd2);
    w_idx_d = qr_idx(r_step, 2'd3);
    w_qa_in = r_work[{w_idx_a, 5'd0} +: 32];
    w_qb_in = r_work[{w_idx_b, 5'd0} +: 32];
    w_qc_in = r_work[{w_idx_c, 5'd0} +: 32];
    w_qd_in = r_work[{w_idx_d, 5'd0} +: 32];
  end

  chacha_qr u_qr (
    .a  (w_qa_in),
    .b  (w_qb_in),
    .c  (w_qc_in),
    .d  (w_qd_in),
    .na (w_qa),
    .nb (w_qb),
    .nc (w_qc),
    .nd (w_qd)
  );

  // Block-counter increment applied to the saved initial state on 'next'
  always_comb begin
    w_init_next          = r_init;
    w_ctr_lo             = r_init[384 +: 32] + 32'd1;
    w_init_next[384 +: 32] = w_ctr_lo;
`ifdef CHACHA_CTR64_EN
    if (w_ctr_lo == 32'd0) begin
      w_init_next[416 +: 32] = r_init[416 +: 32] + 32'd1;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next-state and handshake/status outputs
  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && w_last_beat) w_state_nx = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (w_calc_done) w_state_nx = ST_SUM;
      end
      ST_SUM: begin
        busy = 1'b1;
        if (w_sum_done) w_state_nx = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready && w_last_beat) w_state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        in_ready = 1'b1;
        // A load beat takes priority; a simultaneous 'next' is dropped
        if (in_valid)  w_state_nx = ST_LOAD;
        else if (next) w_state_nx = ST_CALC;
      end
      default: w_state_nx = ST_LOAD;
    endcase
  end

  // Datapath: state load, quarter-rounds, feed-forward add, beat stepping
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_init       <= '0;
      r_work       <= '0;
      r_beat       <= '0;
      r_round      <= '0;
      r_step       <= '0;
      r_key_loaded <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_load_fire) begin
            r_init[w_beat_lsb +: BUS_W] <= in_data;
            r_work[w_beat_lsb +: BUS_W] <= in_data;
            if (w_last_beat) begin
              r_beat       <= '0;
              r_key_loaded <= 1'b1;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        ST_IDLE: begin
          if (w_load_fire) begin
            // Beat 0 of a fresh state is captured here; LOAD takes the rest
            r_init[w_beat_lsb +: BUS_W] <= in_data;
            r_work[w_beat_lsb +: BUS_W] <= in_data;
            r_beat <= r_beat + BEAT_W'(1);
          end else if (next) begin
            r_init <= w_init_next;
            r_work <= w_init_next;
          end
        end
        ST_CALC: begin
          r_work[{w_idx_a, 5'd0} +: 32] <= w_qa;
          r_work[{w_idx_b, 5'd0} +: 32] <= w_qb;
          r_work[{w_idx_c, 5'd0} +: 32] <= w_qc;
          r_work[{w_idx_d, 5'd0} +: 32] <= w_qd;
          r_step <= r_step + 3'd1;
          if (r_step == 3'd7) begin
            r_round <= w_calc_done ? '0 : r_round + RND_W'(1);
          end
        end
        ST_SUM: begin
          r_work[w_sum_lsb +: 32] <= w_sum_word;
          r_beat <= w_sum_done ? '0 : r_beat + BEAT_W'(1);
        end
        ST_OUT: begin
          if (out_ready) begin
            r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chacha_block_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_chacha_block_seq
// Description : Scoreboard bench for chacha_block_seq. Four engines with
//               different ROUNDS/BUS_W share clock and reset; expected
//               keystream beats are queued per engine and a negedge monitor
//               pops and compares each accepted beat.
//               Honours CHACHA_CTR64_EN for the counter-wrap expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chacha_block_seq;

  localparam int NI = 4;

  localparam logic [511:0] RFC_IN = {
    32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
    32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
    32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
    32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  localparam logic [511:0] RFC_OUT = {
    32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
    32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
    32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
    32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid [NI];
  logic [31:0] in_data [NI];
  logic        next_p [NI];
  logic        in_ready_w [NI];
  logic        out_valid_w [NI];
  logic        out_ready_w [NI];
  logic        busy_w [NI];
  logic        key_loaded_w [NI];
  logic [31:0] out_data_w [NI];
  logic        rdy_tgl;
  int          tcyc = 0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [NI][$];
  logic [31:0] held [NI];
  bit          stalled [NI];

  function automatic int bw_of(input int g);
    return (g == 0) ? 8 : (g == 1) ? 32 : 16;
  endfunction

  function automatic int rn_of(input int g);
    return (g <= 1) ? 20 : (g == 2) ? 8 : 12;
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int BW = bw_of(g);
    localparam int RN = rn_of(g);
    logic [BW-1:0] od;
    assign out_ready_w[g] = (g == 1) ? rdy_tgl : 1'b1;
    assign out_data_w[g]  = 32'(od);
    chacha_block_seq #(.ROUNDS(RN), .BUS_W(BW)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready_w[g]),
      .in_data    (in_data[g][BW-1:0]),
      .next       (next_p[g]),
      .out_valid  (out_valid_w[g]),
      .out_ready  (out_ready_w[g]),
      .out_data   (od),
      .busy       (busy_w[g]),
      .key_loaded (key_loaded_w[g])
    );
  end

  // ---------------- reference model (RFC 8439 formulation) ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qrm(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    a = a + b; d = rl(d ^ a, 16); c = c + d; b = rl(b ^ c, 12);
    a = a + b; d = rl(d ^ a, 8);  c = c + d; b = rl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  function automatic logic [511:0] model_block(input logic [511:0] st, input int rounds);
    logic [31:0]  x [16];
    logic [127:0] t;
    logic [511:0] res;
    int           ix [8][4];
    ix = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
           '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    for (int i = 0; i < 16; i++) x[i] = st[i*32 +: 32];
    for (int r = 0; r < rounds; r += 2) begin
      for (int j = 0; j < 8; j++) begin
        t = qrm(x[ix[j][0]], x[ix[j][1]], x[ix[j][2]], x[ix[j][3]]);
        x[ix[j][0]] = t[31:0];
        x[ix[j][1]] = t[63:32];
        x[ix[j][2]] = t[95:64];
        x[ix[j][3]] = t[127:96];
      end
    end
    for (int i = 0; i < 16; i++) res[i*32 +: 32] = x[i] + st[i*32 +: 32];
    return res;
  endfunction

  function automatic logic [511:0] setw(input logic [511:0] s, input int i, input logic [31:0] v);
    s[i*32 +: 32] = v;
    return s;
  endfunction

  function automatic logic [31:0] beat_mask(input int bw);
    return (bw == 32) ? 32'hFFFF_FFFF : ((32'd1 << bw) - 32'd1);
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    for (int g = 0; g < NI; g++) begin
      if (rst_n || !out_valid_w[g]) begin
        stalled[g] = 1'b0;
      end else begin
        if (stalled[g]) begin
          checks++;
          if (out_data_w[g] !== held[g]) begin
            errors++;
            $display("FAIL stall_hold inst%0d got %h want %h", g, out_data_w[g], held[g]);
          end
        end
        if (out_ready_w[g]) begin
          stalled[g] = 1'b0;
          checks++;
          if (exp_q[g].size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat inst%0d got %h want none", g, out_data_w[g]);
          end else begin
            e = exp_q[g].pop_front();
            if (out_data_w[g] !== e) begin
              errors++;
              $display("FAIL beat inst%0d got %h want %h (left %0d)", g, out_data_w[g], e, exp_q[g].size());
            end
          end
        end else begin
          stalled[g] = 1'b1;
          held[g]    = out_data_w[g];
        end
      end
    end
  end

  // Consumer for engine 1 accepts on one cycle in three
  initial begin
    rdy_tgl = 1'b0;
    forever begin
      @(posedge clk); #1;
      tcyc++;
      rdy_tgl = (tcyc % 3 == 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d got %h want %h", nm, g, got, want);
    end
  endtask

  task automatic push_block(input int g, input logic [511:0] blk);
    int bw;
    logic [511:0] t;
    bw = bw_of(g);
    for (int b = 0; b < 512 / bw; b++) begin
      t = blk >> (b * bw);
      exp_q[g].push_back(t[31:0] & beat_mask(bw));
    end
  endtask

  task automatic load_block(input int g, input logic [511:0] st, input bit with_next);
    int bw, guard;
    logic [511:0] t;
    bw = bw_of(g);
    for (int b = 0; b < 512 / bw; b++) begin
      t           = st >> (b * bw);
      in_data[g]  = t[31:0] & beat_mask(bw);
      in_valid[g] = 1'b1;
      next_p[g]   = with_next && (b == 0);
      guard = 0;
      while (!in_ready_w[g] && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 200) begin
        checks++;
        errors++;
        $display("FAIL load_ready inst%0d got 0 want 1 (beat %0d)", g, b);
      end
      @(posedge clk); #1;
    end
    in_valid[g] = 1'b0;
    next_p[g]   = 1'b0;
  endtask

  // Counts cycles from the loading/next edge to first out_valid; optionally
  // pulses 'next' for one cycle at cycle next_at (while the engine is busy).
  task automatic check_latency(input int g, input int want, input int next_at);
    int n;
    n = 0;
    while (!out_valid_w[g] && n < 1000) begin
      @(posedge clk); #1;
      n++;
      next_p[g] = (next_at > 0) && (n == next_at);
    end
    next_p[g] = 1'b0;
    chk("latency", g, n, want);
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    while ((exp_q[g].size() != 0 || out_valid_w[g]) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", g, exp_q[g].size(), 0);
  endtask

  task automatic pulse_next(input int g);
    next_p[g] = 1'b1;
    @(posedge clk); #1;
    next_p[g] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [511:0] s, s2;
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = 1'b0;
      in_data[g]  = '0;
      next_p[g]   = 1'b0;
      held[g]     = '0;
      stalled[g]  = 1'b0;
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_in_ready", g, in_ready_w[g], 1);
      chk("rst_out_valid", g, out_valid_w[g], 0);
      chk("rst_busy", g, busy_w[g], 0);
      chk("rst_key_loaded", g, key_loaded_w[g], 0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;

    // RFC 8439 block vector, byte bus, 20 rounds
    push_block(0, RFC_OUT);
    load_block(0, RFC_IN, 1'b0);
    chk("calc_busy", 0, busy_w[0], 1);
    check_latency(0, 96, 0);
    wait_done(0);
    chk("key_loaded", 0, key_loaded_w[0], 1);

    // 'next' from IDLE: counter 1 -> 2 with no reload
    push_block(0, model_block(setw(RFC_IN, 12, 32'd2), 20));
    pulse_next(0);
    check_latency(0, 96, 0);
    wait_done(0);

    // Counter wrap
    s = setw(setw(RFC_IN, 12, 32'hFFFF_FFFF), 13, 32'd0);
    push_block(0, model_block(s, 20));
    load_block(0, s, 1'b0);
    check_latency(0, 96, 0);
    wait_done(0);
    s2 = setw(s, 12, 32'd0);
`ifdef CHACHA_CTR64_EN
    s2 = setw(s2, 13, 32'd1);
`endif
    push_block(0, model_block(s2, 20));
    pulse_next(0);
    check_latency(0, 96, 0);
    wait_done(0);

    // Load and next together in IDLE: load wins
    s = setw(RFC_IN, 12, 32'd7);
    push_block(0, model_block(s, 20));
    load_block(0, s, 1'b1);
    check_latency(0, 96, 0);
    wait_done(0);

    // 32-bit bus with a stalling consumer
    push_block(1, RFC_OUT);
    load_block(1, RFC_IN, 1'b0);
    check_latency(1, 96, 0);
    wait_done(1);

    // ChaCha8 on a 16-bit bus; 'next' pulsed mid-CALC must be ignored
    push_block(2, model_block(RFC_IN, 8));
    load_block(2, RFC_IN, 1'b0);
    check_latency(2, 48, 10);
    wait_done(2);
    repeat (10) @(posedge clk);
    #1;
    chk("idle_busy", 2, busy_w[2], 0);
    chk("idle_in_ready", 2, in_ready_w[2], 1);

    // ChaCha12 on a 16-bit bus
    s = setw(RFC_IN, 12, 32'd5);
    push_block(3, model_block(s, 12));
    load_block(3, s, 1'b0);
    check_latency(3, 64, 0);
    wait_done(3);

    // Reset during CALC step 37, then a fresh load
    load_block(0, RFC_IN, 1'b0);
    repeat (37) @(posedge clk);
    #1;
    chk("pre_rst_busy", 0, busy_w[0], 1);
    rst_n = 1'b1;
    #2;
    chk("mid_rst_in_ready", 0, in_ready_w[0], 1);
    chk("mid_rst_out_valid", 0, out_valid_w[0], 0);
    chk("mid_rst_busy", 0, busy_w[0], 0);
    chk("mid_rst_key_loaded", 0, key_loaded_w[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    push_block(0, RFC_OUT);
    load_block(0, RFC_IN, 1'b0);
    check_latency(0, 96, 0);
    wait_done(0);
    chk("reload_key_loaded", 0, key_loaded_w[0], 1);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
